// File: rtl/bit_demux_16.sv
// bit_demux_16 -- serial-to-parallel bit collector for the multdiv unit.
//
// Accepts one bit per bit_valid cycle and deposits it into one of 16 slots
// of a holding register. The slot is chosen by the capture counter: slot k
// for the k-th accepted bit (MSB_FIRST=0) or slot 15-k (MSB_FIRST=1). After
// the 16th bit the assembled word is presented with a one-cycle done pulse
// and the block returns to IDLE, holding the word until the next start.
//
// Handshake: an input bit is consumed on a rising clock edge exactly when the
// block is in CAPTURE, bit_valid=1 and start=0. There is no back-pressure;
// the producer may leave gaps (bit_valid=0) of any length between bits.
//
// Priority at each edge: reset > start > bit_valid.

module bit_demux_16 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic [15:0] word_out,
  output logic [4:0]  count,
  output logic        busy,
  output logic        done,
  output logic        dbg_state
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CAPTURE = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_word;
  logic [4:0]  r_count;
  logic        r_busy;
  logic        r_done;

  logic [3:0]  w_pos;
  logic        w_write;
  logic        w_last;

  // Slot addressed by the next accepted bit.
  always_comb begin
    w_pos = r_count[3:0];
    if (MSB_FIRST) begin
      w_pos = 4'd15 - r_count[3:0];
    end
  end

  // A bit is consumed only in CAPTURE, without a competing start, and never
  // past the 16th slot (the counter saturates rather than wrapping).
  assign w_write = (r_state == S_CAPTURE) && bit_valid && !start
                   && (r_count != 5'd16);
  assign w_last  = w_write && (r_count == 5'd15);

  // Capture FSM with all outputs registered; done defaults low every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= 16'h0000;
      r_count <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_word  <= 16'h0000;
            r_count <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (start) begin
            // Restart: abandon the partial word, stay in CAPTURE.
            r_word  <= 16'h0000;
            r_count <= 5'd0;
            r_busy  <= 1'b1;
          end else if (w_write) begin
            r_word[w_pos] <= bit_in;
            r_count       <= r_count + 5'd1;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign word_out  = r_word;
  assign count     = r_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bit_demux_16.sv
// tb_bit_demux_16 -- self-checking bench for bit_demux_16.
// Both parameterisations (MSB_FIRST=0 and 1) run side by side on the same
// input stream; each has its own expected-word queue.

module tb_bit_demux_16;

  logic        clock;
  logic        reset;
  logic        start;
  logic        bit_valid;
  logic        bit_in;

  logic [15:0] w0, w1;
  logic [4:0]  c0, c1;
  logic        b0, b1, d0, d1, s0, s1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  bit_demux_16 #(.MSB_FIRST(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .bit_valid(bit_valid),
    .bit_in(bit_in), .word_out(w0), .count(c0), .busy(b0), .done(d0),
    .dbg_state(s0)
  );

  bit_demux_16 #(.MSB_FIRST(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .bit_valid(bit_valid),
    .bit_in(bit_in), .word_out(w1), .count(c1), .busy(b1), .done(d1),
    .dbg_state(s1)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15 - i];
    return r;
  endfunction

  task automatic push_expected(input logic [15:0] v);
    exp_q0.push_back(v);
    exp_q1.push_back(rev16(v));
  endtask

  // Driver: start a capture, check the cleared/busy state one edge later.
  task automatic do_start(input string tag, input logic with_valid);
    start = 1'b1; bit_valid = with_valid; bit_in = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    n_checks++;
    if ({w0, c0, b0, d0} !== {16'h0000, 5'd0, 1'b1, 1'b0}) begin
      $display("FAIL %s start0: got w=%h c=%0d b=%b d=%b want w=0000 c=0 b=1 d=0", tag, w0, c0, b0, d0);
    end else n_pass++;
    n_checks++;
    if ({w1, c1, b1, d1} !== {16'h0000, 5'd0, 1'b1, 1'b0}) begin
      $display("FAIL %s start1: got w=%h c=%0d b=%b d=%b want w=0000 c=0 b=1 d=0", tag, w1, c1, b1, d1);
    end else n_pass++;
  endtask

  // Driver: feed the low nbits of val LSB first, optionally with a one-cycle
  // gap after each bit; checks every intermediate state and, on the 16th
  // bit, pops the scoreboard.
  task automatic feed(input string tag, input logic [15:0] val, input int nbits, input bit gaps);
    logic [15:0] p0, p1, e;
    p0 = 16'h0000; p1 = 16'h0000;
    for (int k = 0; k < nbits; k++) begin
      bit_valid = 1'b1; bit_in = val[k];
      tick();
      bit_valid = 1'b0;
      p0[k] = val[k];
      p1[15 - k] = val[k];
      n_checks++;
      if ({w0, c0, b0, d0} !== {p0, 5'(k + 1), (k != 15), (k == 15)}) begin
        $display("FAIL %s bit%0d dut0: got w=%h c=%0d b=%b d=%b want w=%h c=%0d b=%b d=%b",
                 tag, k, w0, c0, b0, d0, p0, k + 1, (k != 15), (k == 15));
      end else n_pass++;
      n_checks++;
      if ({w1, c1, b1, d1} !== {p1, 5'(k + 1), (k != 15), (k == 15)}) begin
        $display("FAIL %s bit%0d dut1: got w=%h c=%0d b=%b d=%b want w=%h c=%0d b=%b d=%b",
                 tag, k, w1, c1, b1, d1, p1, k + 1, (k != 15), (k == 15));
      end else n_pass++;
      if (d0 === 1'b1) begin
        n_checks++;
        if (exp_q0.size() == 0) begin
          $display("FAIL %s sb0: done with empty queue, got w=%h", tag, w0);
        end else begin
          e = exp_q0.pop_front();
          if (w0 !== e) $display("FAIL %s sb0: got w=%h want w=%h", tag, w0, e);
          else n_pass++;
        end
      end
      if (d1 === 1'b1) begin
        n_checks++;
        if (exp_q1.size() == 0) begin
          $display("FAIL %s sb1: done with empty queue, got w=%h", tag, w1);
        end else begin
          e = exp_q1.pop_front();
          if (w1 !== e) $display("FAIL %s sb1: got w=%h want w=%h", tag, w1, e);
          else n_pass++;
        end
      end
      if (gaps && (k < 15)) begin
        bit_in = 1'($urandom_range(0, 1));
        tick();
        n_checks++;
        if ({w0, c0, b0, d0, w1, c1, b1, d1} !==
            {p0, 5'(k + 1), 1'b1, 1'b0, p1, 5'(k + 1), 1'b1, 1'b0}) begin
          $display("FAIL %s gap%0d: got w0=%h c0=%0d b0=%b d0=%b w1=%h c1=%0d b1=%b d1=%b want w0=%h w1=%h c=%0d b=1 d=0",
                   tag, k, w0, c0, b0, d0, w1, c1, b1, d1, p0, p1, k + 1);
        end else n_pass++;
      end
    end
  endtask

  // Idle hold after completion: done must fall, word and count must hold.
  task automatic check_idle_hold(input string tag, input logic [15:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bit_valid = 1'b1; bit_in = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if ({w0, c0, b0, d0, w1, c1, b1, d1} !==
          {v, 5'd16, 1'b0, 1'b0, rev16(v), 5'd16, 1'b0, 1'b0}) begin
        $display("FAIL %s hold%0d: got w0=%h c0=%0d b0=%b d0=%b w1=%h c1=%0d b1=%b d1=%b want w0=%h w1=%h c=16 b=0 d=0",
                 tag, i, w0, c0, b0, d0, w1, c1, b1, d1, v, rev16(v));
      end else n_pass++;
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = i[0]; bit_in = 1'b1;
      tick();
      n_checks++;
      if ({w0, c0, b0, d0, w1, c1, b1, d1} !== '0) begin
        $display("FAIL reset_idle%0d: got w0=%h c0=%0d b0=%b d0=%b w1=%h c1=%0d b1=%b d1=%b want all 0",
                 i, w0, c0, b0, d0, w1, c1, b1, d1);
      end else n_pass++;
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_contiguous();
    do_start("contig", 1'b1);
    push_expected(16'hA5C3);
    feed("contig", 16'hA5C3, 16, 1'b0);
    n_checks++;
    if ({w0, w1} !== {16'hA5C3, 16'hC3A5}) begin
      $display("FAIL contig_final: got w0=%h w1=%h want w0=a5c3 w1=c3a5", w0, w1);
    end else n_pass++;
    check_idle_hold("contig", 16'hA5C3, 3);
  endtask

  task automatic test_gapped();
    do_start("gapped", 1'b0);
    push_expected(16'hFFFF);
    feed("gapped", 16'hFFFF, 16, 1'b1);
    check_idle_hold("gapped", 16'hFFFF, 1);
  endtask

  task automatic test_restart();
    do_start("restart", 1'b0);
    feed("restart_a", 16'h03FF, 10, 1'b0);
    do_start("restart_b", 1'b1);
    push_expected(16'h1234);
    feed("restart_c", 16'h1234, 16, 1'b0);
    check_idle_hold("restart", 16'h1234, 1);
    // Start on the cycle that would carry the 16th bit: no done.
    do_start("restart16", 1'b0);
    feed("restart16_a", 16'hFFFF, 15, 1'b0);
    do_start("restart16_b", 1'b1);
    push_expected(16'h8001);
    feed("restart16_c", 16'h8001, 16, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_start("rstmid", 1'b0);
    feed("rstmid", 16'h007F, 7, 1'b0);
    reset = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({w0, c0, b0, d0, w1, c1, b1, d1} !== '0) begin
        $display("FAIL rstmid%0d: got w0=%h c0=%0d b0=%b d0=%b w1=%h c1=%0d b1=%b d1=%b want all 0",
                 i, w0, c0, b0, d0, w1, c1, b1, d1);
      end else n_pass++;
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
  endtask

  // Start in the done cycle, then random words with random gap choice.
  task automatic test_back_to_back();
    logic [15:0] v;
    do_start("b2b", 1'b0);
    push_expected(16'h5A5A);
    feed("b2b_a", 16'h5A5A, 16, 1'b0);
    for (int n = 0; n < 4; n++) begin
      v = 16'($urandom_range(0, 65535));
      do_start("b2b", 1'($urandom_range(0, 1)));
      push_expected(v);
      feed("b2b_r", v, 16, 1'($urandom_range(0, 1)));
    end
    check_idle_hold("b2b", v, 2);
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gapped();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if ((exp_q0.size() != 0) || (exp_q1.size() != 0)) begin
      $display("FAIL sb_drain: got q0=%0d q1=%0d entries left want 0", exp_q0.size(), exp_q1.size());
    end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
